// File: rtl/light_music_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : light_music_pkg
//  Purpose  : Shared widths and helpers for the light-music lamp channels.
//  Revision : 1.0  initial release
// ============================================================================
package light_music_pkg;

  localparam int ENV_W    = 16;  // envelope / scaled magnitude width
  localparam int LVL_W    = 8;   // lamp level and PWM width
  localparam int SAMPLE_W = 48;  // filter output width handled by sat_abs

  // Saturating absolute value of a signed filter sample. The most negative
  // input has no positive twin, so it clamps to the largest positive value.
  function automatic logic [SAMPLE_W-2:0] sat_abs(input logic signed [SAMPLE_W-1:0] x);
    logic [SAMPLE_W-1:0] neg;
    neg = $unsigned(-x);
    if (!x[SAMPLE_W-1]) begin
      return x[SAMPLE_W-2:0];
    end
    if (neg[SAMPLE_W-1]) begin
      return '1;
    end
    return neg[SAMPLE_W-2:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_gen
//  Purpose  : Free-running lamp PWM; duty is shadow-loaded at each counter
//             wrap so a level change never produces a runt pulse.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_gen
  import light_music_pkg::*;
#(
  parameter int PWM_W = LVL_W
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [PWM_W-1:0] level,
  output logic             pwm_out
);

  logic [PWM_W-1:0] cnt_q;
  logic [PWM_W-1:0] duty_q;
  logic             pwm_q;

  // Counter wraps freely; duty latched on the last count; output registered.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + PWM_W'(1);
      if (&cnt_q) begin
        duty_q <= level;
      end
      pwm_q <= (cnt_q < duty_q);
    end
  end

  assign pwm_out = pwm_q;

endmodule
`default_nettype wire

// File: rtl/band_level_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : band_level_pwm
//  Purpose  : Turns the band filter's sample stream into a fast-attack /
//             slow-decay envelope and drives one lamp PWM from it.
//  Revision : 1.0  initial release
// ============================================================================
module band_level_pwm
  import light_music_pkg::*;
#(
  parameter int IN_W     = SAMPLE_W,
  parameter int SHIFT    = 20,
  parameter int DECAY_SH = 6,
  parameter int PWM_W    = LVL_W
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic signed [IN_W-1:0] in_val,
  input  logic                   in_ready,
  output logic [PWM_W-1:0]       level,
  output logic                   pwm_out
);

  localparam int c_MAG_W = IN_W - 1;

  logic               rdy_q;
  logic               v1_q;
  logic               v2_q;
  logic [c_MAG_W-1:0] mag_q;
  logic [ENV_W-1:0]   sc_q;
  logic [ENV_W-1:0]   env_q;
  logic [ENV_W-1:0]   env_d;

  logic               w_accept;
  logic [c_MAG_W-1:0] w_mag;
  logic [c_MAG_W-1:0] w_shifted;
  logic [ENV_W-1:0]   w_sc;
  logic [ENV_W-1:0]   w_decay;

  // Rising edge of the ready strobe; rdy_q resets high so a strobe that is
  // already asserted when reset lifts is ignored.
  assign w_accept = in_ready & ~rdy_q;

  assign w_mag     = sat_abs(in_val);
  assign w_shifted = mag_q >> SHIFT;
  // Anything above the 16-bit envelope range pins to full scale.
  assign w_sc      = (|w_shifted[c_MAG_W-1:ENV_W]) ? '1 : w_shifted[ENV_W-1:0];

  // Envelope next value: jump up on attack, otherwise decay proportionally
  // with a minimum step of one so the level always reaches zero.
  always_comb begin
    w_decay = env_q >> DECAY_SH;
    if (w_decay == '0) begin
      w_decay = ENV_W'(1);
    end
    env_d = '0;
    if (sc_q >= env_q) begin
      env_d = sc_q;
    end else if (env_q > w_decay) begin
      env_d = env_q - w_decay;
    end
  end

  // Strobe edge detector history.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rdy_q <= 1'b1;
    end else begin
      rdy_q <= in_ready;
    end
  end

  // Three-stage pipeline: magnitude, scale/clamp, envelope update.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      mag_q <= '0;
      sc_q  <= '0;
      env_q <= '0;
    end else begin
      v1_q <= w_accept;
      if (w_accept) begin
        mag_q <= w_mag;
      end
      v2_q <= v1_q;
      sc_q <= w_sc;
      if (v2_q) begin
        env_q <= env_d;
      end
    end
  end

  assign level = env_q[ENV_W-1 -: PWM_W];

  pwm_gen #(
    .PWM_W (PWM_W)
  ) u_pwm (
    .clk     (clk),
    .nreset  (nreset),
    .level   (level),
    .pwm_out (pwm_out)
  );

endmodule
`default_nettype wire

// File: doc/band_level_pwm.md
# band_level_pwm

Consumer of the FIR band filter's output stream. Takes each filtered sample on the rising edge of the filter's ready strobe, converts it to a magnitude, and tracks it with a fast-attack/slow-decay envelope. Drives one lamp channel with an 8-bit PWM whose duty equals the envelope level. One instance sits behind each band filter, between `fir_filter` and the lamp driver pins.

## Interface
- `IN_W`, 48: width of the signed filter output.
- `SHIFT`, 20: right shift that maps magnitude to the 16-bit envelope scale.
- `DECAY_SH`, 6: envelope decay per accepted sample is `env >> DECAY_SH`.
- `PWM_W`, 8: PWM counter and level width.
- `clk` in 1: single clock, same domain as the filter's `clk`.
- `nreset` in 1: asynchronous, active-low reset.
- `in_val` in IN_W: signed filter output (`out_val`); stable while `in_ready` is high.
- `in_ready` in 1: filter ready strobe (`out_ready`); may stay high for several cycles.
- `level` out PWM_W: current envelope level, `env[15:8]`.
- `pwm_out` out 1: registered lamp PWM.

## Operation
- Edge detect: `rdy_d <= in_ready`; accept when `in_ready & ~rdy_d`. `rdy_d` resets to 1, so a strobe already high at reset release is not accepted.
- The pipeline has three register stages, with no stalls:
  - S1, on accept: `mag = |in_val|`. The value −2^(IN_W−1) saturates to 2^(IN_W−1)−1. `v1 <= 1`.
  - S2: `sc = mag >> SHIFT`, clamped to 65535. `v2 <= v1`.
  - S3, when `v2`:
    - If `sc >= env`, then `env <= sc` (attack).
    - Otherwise `env <= env − max(env >> DECAY_SH, 1)`, floored at 0.
    - This guarantees decay reaches 0.
- `level` is combinational from `env[15:8]`.
- PWM:
  - `cnt` free-runs 0..2^PWM_W−1 and wraps.
  - When `cnt` reaches its maximum, `duty <= level` (shadow load, glitch-free).
  - `pwm_out <= (cnt < duty)`.
  - duty 0 gives always low. duty 255 gives high for 255 of every 256 cycles.
- Accept edges arrive at least 2 cycles apart, because `in_ready` must fall in between. Overlapping samples in flight are therefore processed independently in order.

## Timing
- Reset values: `env`, `cnt`, `duty`, `v1`, `v2`, `level`, `pwm_out` = 0; `rdy_d` = 1.
- Latency: an accept sampled at clock edge k updates `env` (and `level`) at edge k+2.
- `pwm_out` reflects a new level from the first PWM period starting after the next `cnt` wrap. That is at most 2^PWM_W + 1 cycles after the `env` update.
- Reset mid-operation forces all registers to their reset values immediately (asynchronous). The first accept after release requires a fresh 0→1 on `in_ready`.
- Arithmetic: `mag` is IN_W−1 bits unsigned; `env` and `sc` are 16 bits unsigned. There is no wrap anywhere, only clamping.

## Structure
- Shared package `light_music_pkg`: `ENV_W = 16`, `LVL_W = 8`, and the `sat_abs` function for the IN_W-wide saturating absolute value.
- Sub-module `pwm_gen` contains `cnt`, `duty`, and `pwm_out`, with inputs `clk`, `nreset`, `level`. It is reused by the other lamp channels.
- The top holds the edge detect, the S1–S3 pipeline and the envelope. Target size is about 150 lines.

## Test plan
- **Reset with strobe held high:** `nreset` 0→1 while `in_ready`=1 and `in_val`=2^40 → no accept; `env`=0, `level`=0, `pwm_out`=0 throughout.
- **Positive sample:** `in_val`=17179869184 (16384·2^20), strobe edge → `env`=16384 two edges after accept, `level`=64. After the next wrap, `pwm_out` is high exactly 64 of 256 cycles.
- **Negative and saturation:**
  - `in_val`=−17179869184 → `env`=16384.
  - `in_val`=−2^47 → `env`=65535, `level`=255, and `pwm_out` is low exactly 1 cycle per 256.
- **Decay:**
  - From `env`=16384, repeated strobes with `in_val`=0 → 16128, then 15876.
  - From `env`=40 → 39, then 38, reaching exactly 0 and staying there.
- **Long strobe and back-to-back:** `in_ready` high for 5 cycles is counted as one accept only. Strobes of 1-high/1-low with values 65535·2^20 then 0 → `env` 65535, then 64512.
- **Reset mid-PWM:** assert `nreset` while `pwm_out`=1 and `level`=128 → `pwm_out`, `level` and `env` are 0 within the same cycle and remain 0 until a new accept.
